// File: rtl/bit_compose_agen_pkg.sv
// rtl/bit_compose_agen_pkg.sv - shared types, sizing constants and mid-field rotate helpers
package bit_compose_agen_pkg;

    localparam int LOG_N        = 16;
    localparam int LOG_E        = 3;
    localparam int AG_WIDTH     = LOG_N - LOG_E;
    localparam int AG_MID_WIDTH = LOG_E;

    typedef enum logic [1:0] {AG_IDLE, AG_RUN, AG_DONE} agen_state_t;

    // Rotations operate on the low w bits of v; amt must already be reduced below w.
    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned amt,
                                         input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return ((v << amt) | (v >> (w - amt))) & mask;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned amt,
                                         input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (amt == 0) ? (v & mask) : rotl(v, w - amt, w);
    endfunction

endpackage

// File: rtl/bit_compose_agen_lane.sv
// rtl/bit_compose_agen_lane.sv - one lane: rotate the lane index and insert it into the counter bits
module bit_compose_lane
    import bit_compose_agen_pkg::*;
#(
    parameter int  WIDTH     = AG_WIDTH,
    parameter int  MID_WIDTH = AG_MID_WIDTH,
    localparam int IN_W      = WIDTH - MID_WIDTH,
    localparam int BASE_W    = $clog2(IN_W + 1),
    localparam int ROT_W     = (MID_WIDTH > 1) ? $clog2(MID_WIDTH) : 1
) (
    input  logic [IN_W-1:0]      i_in,
    input  logic [MID_WIDTH-1:0] i_mid,
    input  logic [BASE_W-1:0]    i_base,
    input  logic [ROT_W-1:0]     i_barrel,
    input  logic                 i_left,
    output logic [WIDTH-1:0]     o_addr
);

    int unsigned      w_b;
    logic [WIDTH-1:0] w_midr;
    logic [WIDTH-1:0] w_in_ext;
    logic [WIDTH-1:0] w_low;

    // The split point is a mask so the insert works for every base without a mux tree.
    always_comb begin
        w_b      = (int'(i_base) > IN_W) ? IN_W : int'(i_base);
        w_midr   = i_left ? WIDTH'(rotl(32'(i_mid), 32'(i_barrel), MID_WIDTH))
                          : WIDTH'(rotr(32'(i_mid), 32'(i_barrel), MID_WIDTH));
        w_in_ext = WIDTH'(i_in);
        w_low    = (WIDTH'(1) << w_b) - WIDTH'(1);
        o_addr   = ((w_in_ext & ~w_low) << MID_WIDTH) | (w_midr << w_b) | (w_in_ext & w_low);
    end

endmodule

// File: rtl/bit_compose_agen.sv
// rtl/bit_compose_agen.sv - streaming composed-address sweep; optional BIT_COMPOSE_BITREV_EN adds bit-reversed counter order
module bit_compose_agen
    import bit_compose_agen_pkg::*;
#(
    parameter int  WIDTH     = AG_WIDTH,
    parameter int  MID_WIDTH = AG_MID_WIDTH,
    localparam int IN_W      = WIDTH - MID_WIDTH,
    localparam int LANES     = 2 ** MID_WIDTH,
    localparam int BASE_W    = $clog2(IN_W + 1),
    localparam int ROT_W     = (MID_WIDTH > 1) ? $clog2(MID_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [BASE_W-1:0]      cmd_base,
    input  logic [ROT_W-1:0]       cmd_barrel,
    input  logic                   cmd_left,
    input  logic [IN_W-1:0]        cmd_len,
`ifdef BIT_COMPOSE_BITREV_EN
    input  logic                   cmd_bitrev,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_addr,
    output logic                   out_last,
    output logic                   done,
    output logic                   busy
);

    agen_state_t            r_state;
    agen_state_t            w_state_nxt;
    logic [BASE_W-1:0]      r_base;
    logic [BASE_W-1:0]      w_base;
    logic [ROT_W-1:0]       r_barrel;
    logic [ROT_W-1:0]       w_barrel;
    logic                   r_left;
    logic                   w_left;
    logic [IN_W-1:0]        r_len;
    logic [IN_W-1:0]        w_len;
    logic [IN_W-1:0]        r_cnt;
    logic [IN_W-1:0]        w_cnt_nxt;
    logic [IN_W-1:0]        w_in;
    logic [LANES*WIDTH-1:0] r_addr;
    logic [LANES*WIDTH-1:0] w_lanes;
    logic                   r_last;
    logic                   w_last_nxt;
    logic                   w_idle;
    logic                   w_fire_cmd;
    logic                   w_fire_out;

    assign w_idle     = (r_state == AG_IDLE);
    assign w_fire_cmd = w_idle && cmd_valid;
    assign w_fire_out = (r_state == AG_RUN) && out_ready;

    // In IDLE the lanes see the raw command so beat 0 is registered on the accepting edge.
    always_comb begin
        w_base     = w_idle ? cmd_base : r_base;
        w_barrel   = w_idle ? ROT_W'(32'(cmd_barrel) % MID_WIDTH) : r_barrel;
        w_left     = w_idle ? cmd_left : r_left;
        w_len      = w_idle ? cmd_len : r_len;
        w_cnt_nxt  = w_idle ? '0 : r_cnt + 1'b1;
        w_last_nxt = (w_cnt_nxt == w_len - 1'b1);
    end

`ifdef BIT_COMPOSE_BITREV_EN
    logic r_bitrev;
    logic w_bitrev;

    always_comb begin
        w_bitrev = w_idle ? cmd_bitrev : r_bitrev;
        w_in     = w_cnt_nxt;
        if (w_bitrev) begin
            for (int i = 0; i < IN_W; i++) begin
                w_in[i] = w_cnt_nxt[IN_W-1-i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitrev <= 1'b0;
        end else if (w_fire_cmd) begin
            r_bitrev <= cmd_bitrev;
        end
    end
`else
    assign w_in = w_cnt_nxt;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bit_compose_lane #(
            .WIDTH     (WIDTH),
            .MID_WIDTH (MID_WIDTH)
        ) u_lane (
            .i_in     (w_in),
            .i_mid    (MID_WIDTH'(g)),
            .i_base   (w_base),
            .i_barrel (w_barrel),
            .i_left   (w_left),
            .o_addr   (w_lanes[g*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= AG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AG_IDLE: if (cmd_valid) w_state_nxt = AG_RUN;
            AG_RUN:  if (out_ready && r_last) w_state_nxt = AG_DONE;
            AG_DONE: w_state_nxt = AG_IDLE;
            default: w_state_nxt = AG_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = w_idle && !rst;
        out_valid = (r_state == AG_RUN);
        done      = (r_state == AG_DONE);
        busy      = !w_idle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_barrel <= '0;
            r_left   <= 1'b0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_last   <= 1'b0;
        end else if (w_fire_cmd) begin
            r_base   <= w_base;
            r_barrel <= w_barrel;
            r_left   <= w_left;
            r_len    <= w_len;
            r_cnt    <= '0;
            r_addr   <= w_lanes;
            r_last   <= w_last_nxt;
        end else if (w_fire_out) begin
            // The counter stops on the final beat so a full sweep never shows a wrap.
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_addr <= w_lanes;
                r_last <= w_last_nxt;
            end
        end
    end

    assign out_addr = r_addr;
    assign out_last = r_last;

endmodule

// File: tb/tb_bit_compose_agen.sv
// tb/tb_bit_compose_agen.sv - vector table plus scoreboard bench for bit_compose_agen
module tb_bit_compose_agen;

    localparam int WIDTH     = 13;
    localparam int MID_WIDTH = 3;
    localparam int IN_W      = WIDTH - MID_WIDTH;
    localparam int LANES     = 2 ** MID_WIDTH;
    localparam int BASE_W    = $clog2(IN_W + 1);
    localparam int ROT_W     = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [BASE_W-1:0]      cmd_base;
    logic [ROT_W-1:0]       cmd_barrel;
    logic                   cmd_left;
    logic [IN_W-1:0]        cmd_len;
`ifdef BIT_COMPOSE_BITREV_EN
    logic                   cmd_bitrev;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_addr;
    logic                   out_last;
    logic                   done;
    logic                   busy;

    bit_compose_agen dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_barrel (cmd_barrel),
        .cmd_left   (cmd_left),
        .cmd_len    (cmd_len),
`ifdef BIT_COMPOSE_BITREV_EN
        .cmd_bitrev (cmd_bitrev),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    base;
        int    barrel;
        bit    left;
        int    len;
        bit    brev;
        int    stall_beat;
        int    stall_cycles;
        int    tgt_beat;
        int    tgt_lane;
        int    tgt_exp;
        string name;
    } vec_t;

    typedef struct {
        logic [LANES*WIDTH-1:0] addr;
        logic                   last;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_lane(input int cnt, input int lane, input int base,
                                                    input int barrel, input bit left, input bit brev);
        int          in_v;
        int          m;
        int          b;
        logic [31:0] o;
        in_v = cnt;
        if (brev) begin
            in_v = 0;
            for (int i = 0; i < IN_W; i++)
                if (((cnt >> i) & 1) != 0) in_v |= 1 << (IN_W - 1 - i);
        end
        m = lane;
        for (int s = 0; s < barrel % MID_WIDTH; s++)
            m = left ? (((m << 1) | (m >> (MID_WIDTH - 1))) & (LANES - 1))
                     : ((m >> 1) | ((m & 1) << (MID_WIDTH - 1)));
        b = (base > IN_W) ? IN_W : base;
        o = 32'(((in_v >> b) << (b + MID_WIDTH)) | (m << b) | (in_v & ((1 << b) - 1)));
        return o[WIDTH-1:0];
    endfunction

    task automatic push_expected(input vec_t v);
        int    nb;
        beat_t e;
        nb = (v.len == 0) ? (1 << IN_W) : v.len;
        for (int k = 0; k < nb; k++) begin
            for (int l = 0; l < LANES; l++)
                e.addr[l*WIDTH +: WIDTH] = model_lane(k, l, v.base, v.barrel, v.left, v.brev);
            e.last = (k == nb - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_base   = BASE_W'(v.base);
        cmd_barrel = ROT_W'(v.barrel);
        cmd_left   = v.left;
        cmd_len    = IN_W'(v.len);
`ifdef BIT_COMPOSE_BITREV_EN
        cmd_bitrev = v.brev;
`endif
        cmd_valid  = 1'b1;
        push_expected(v);
    endtask

    task automatic pop_compare();
        beat_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("beat_addr", out_addr, e.addr);
            chk("beat_last", out_last, e.last);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int                     k;
        int                     stalls;
        int                     guard;
        bit                     last_seen;
        logic [LANES*WIDTH-1:0] hold_addr;
        logic                   hold_last;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        drive_cmd(v);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0; stalls = 0; last_seen = 0;
        hold_addr = '0; hold_last = 1'b0;
        for (guard = 0; guard < 3000 && !last_seen; guard++) begin
            chk("out_valid_run", out_valid, 1);
            if (k == v.stall_beat && stalls < v.stall_cycles) begin
                if (stalls == 0) begin
                    hold_addr = out_addr;
                    hold_last = out_last;
                end else begin
                    chk("stall_addr_stable", out_addr, hold_addr);
                    chk("stall_last_stable", out_last, hold_last);
                end
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
                if (k == v.tgt_beat)
                    chk(v.name, out_addr[v.tgt_lane*WIDTH +: WIDTH], v.tgt_exp);
                pop_compare();
                if (out_last === 1'b1 || sb_q.size() == 0) last_seen = 1;
                k++;
            end
            @(posedge clk); #1;
        end
        chk("sweep_finished", last_seen, 1);
        chk("done_pulse", done, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("sb_empty", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_barrel = '0; cmd_left = 1'b0;
        cmd_len = '0; out_ready = 1'b0;
`ifdef BIT_COMPOSE_BITREV_EN
        cmd_bitrev = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);
        @(posedge clk); #1;

        vecs.push_back('{0, 0, 1'b0, 8, 1'b0, -1, 0, 5, 0, 40, "basic_b5_l0"});
        vecs.push_back('{0, 0, 1'b0, 8, 1'b0, -1, 0, 5, 7, 47, "basic_b5_l7"});
        vecs.push_back('{2, 1, 1'b0, 0, 1'b0, -1, 0, 1023, 1, 8179, "rotr_full_l1"});
        vecs.push_back('{15, 1, 1'b1, 8, 1'b0, -1, 0, 3, 1, 2051, "rotl_clamp_l1"});
        vecs.push_back('{10, 0, 1'b0, 4, 1'b0, -1, 0, 3, 7, 7171, "base_top_l7"});
        vecs.push_back('{3, 2, 1'b1, 16, 1'b0, 2, 3, 2, 5, 50, "backpressure_l5"});
        vecs.push_back('{0, 3, 1'b0, 2, 1'b0, -1, 0, 1, 2, 10, "barrel_mod_l2"});
`ifdef BIT_COMPOSE_BITREV_EN
        vecs.push_back('{0, 0, 1'b0, 4, 1'b1, -1, 0, 1, 0, 4096, "bitrev_l0"});
        vecs.push_back('{0, 0, 1'b0, 4, 1'b1, -1, 0, 1, 3, 4099, "bitrev_l3"});
`endif
        foreach (vecs[i]) run_vec(vecs[i]);

        // Busy rejection then reset mid-sweep at beat 4 of 8.
        rv = '{0, 0, 1'b0, 8, 1'b0, -1, 0, -1, 0, 0, "abort"};
        drive_cmd(rv);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_out_valid", out_valid, 1);
            if (k == 1) begin
                cmd_valid = 1'b1;
                cmd_base  = BASE_W'(5);
                cmd_len   = IN_W'(3);
                chk("busy_cmd_ready", cmd_ready, 0);
            end else begin
                cmd_valid = 1'b0;
            end
            out_ready = 1'b1;
            pop_compare();
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("beat4_valid", out_valid, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_out_valid_rst", out_valid, 0);
        chk("abort_busy_rst", busy, 0);
        chk("abort_done_rst", done, 0);
        chk("abort_cmd_ready_rst", cmd_ready, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_cmd_ready_release", cmd_ready, 1);
        @(posedge clk); #1;
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
